// File: rtl/hazard_forward_controller_if.sv
// ID-stage instruction fields and EX-stage control outputs exchanged with the
// hazard/forwarding controller.
interface hazard_forward_controller_if #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
);
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_rd;
  logic             id_uses_rt;
  logic             id_RegDst;
  logic             id_RegWrite;
  logic             id_MemRead;
  logic             ex_branch_taken;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             flush;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_RegDst,
           id_RegWrite, id_MemRead, ex_branch_taken,
    input  pc_write, ifid_write, idex_bubble, flush, forward_a, forward_b,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rt, id_RegDst,
           id_RegWrite, id_MemRead, ex_branch_taken,
    output pc_write, ifid_write, idex_bubble, flush, forward_a, forward_b,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_forward_controller.sv
// EX-stage pipeline controller: EX/MEM/WB scoreboard, ALU operand forwarding,
// load-use stall, taken-branch flush and saturating debug event counters.
module hazard_forward_controller #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  hazard_forward_controller_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] dest;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } slot_t;

  slot_t            r_ex;
  slot_t            r_mem;
  slot_t            r_wb;
  logic [CNT_W-1:0] r_stallCount;
  logic [CNT_W-1:0] r_flushCount;

  logic             w_stall;
  logic             w_flush;
  slot_t            w_idSlot;
  logic [1:0]       w_fwdA;
  logic [1:0]       w_fwdB;
  logic             w_unused;

  // Flush wins: an ID instruction that is being squashed must not also stall.
  always_comb begin
    w_flush = 1'b0;
    w_stall = 1'b0;
    if (!reset) begin
      w_flush = r_ex.valid & bus.ex_branch_taken;
      w_stall = bus.id_valid & r_ex.valid & r_ex.memread & (r_ex.dest != '0) &
                ((r_ex.dest == bus.id_rs) |
                 (bus.id_uses_rt & (r_ex.dest == bus.id_rt))) &
                !w_flush;
    end
  end

  always_comb begin
    w_idSlot          = '0;
    w_idSlot.valid    = 1'b1;
    w_idSlot.regwrite = bus.id_RegWrite;
    w_idSlot.memread  = bus.id_MemRead;
    w_idSlot.dest     = bus.id_RegDst ? bus.id_rd : bus.id_rt;
    w_idSlot.rs       = bus.id_rs;
    w_idSlot.rt       = bus.id_rt;
  end

  // A load sitting in MEM is never a source; the stall puts it in WB first.
  always_comb begin
    w_fwdA = 2'b00;
    w_fwdB = 2'b00;
    if (!reset) begin
      if (r_mem.valid & r_mem.regwrite & !r_mem.memread &
          (r_mem.dest != '0) & (r_mem.dest == r_ex.rs))
        w_fwdA = 2'b10;
      else if (r_wb.valid & r_wb.regwrite & (r_wb.dest != '0) &
               (r_wb.dest == r_ex.rs))
        w_fwdA = 2'b01;

      if (r_ex.valid) begin
        if (r_mem.valid & r_mem.regwrite & !r_mem.memread &
            (r_mem.dest != '0) & (r_mem.dest == r_ex.rt))
          w_fwdB = 2'b10;
        else if (r_wb.valid & r_wb.regwrite & (r_wb.dest != '0) &
                 (r_wb.dest == r_ex.rt))
          w_fwdB = 2'b01;
      end
    end
  end

  always_comb begin
    bus.pc_write    = 1'b1;
    bus.ifid_write  = 1'b1;
    bus.idex_bubble = 1'b0;
    bus.flush       = 1'b0;
    if (w_flush) begin
      bus.idex_bubble = 1'b1;
      bus.flush       = 1'b1;
    end else if (w_stall) begin
      bus.pc_write    = 1'b0;
      bus.ifid_write  = 1'b0;
      bus.idex_bubble = 1'b1;
    end
  end

  assign bus.forward_a   = w_fwdA;
  assign bus.forward_b   = w_fwdB;
  assign bus.stall_count = r_stallCount;
  assign bus.flush_count = r_flushCount;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex         <= '0;
      r_mem        <= '0;
      r_wb         <= '0;
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      r_ex  <= (bus.id_valid & !w_stall & !w_flush) ? w_idSlot : '0;
      if (w_stall && (r_stallCount != {CNT_W{1'b1}}))
        r_stallCount <= r_stallCount + CNT_W'(1);
      if (w_flush && (r_flushCount != {CNT_W{1'b1}}))
        r_flushCount <= r_flushCount + CNT_W'(1);
    end
  end

  // Slot fields kept for debug visibility but not consumed by the decode.
  assign w_unused = ^{r_mem.rs, r_mem.rt, r_wb.memread, r_wb.rs, r_wb.rt};

endmodule

// File: tb/tb_hazard_forward_controller.sv
// Directed table-driven bench for hazard_forward_controller, with hand-written
// sequences for reset behaviour and counter saturation.
module tb_hazard_forward_controller;

  localparam int N = 0;
  localparam int S = 1;
  localparam int F = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  hazard_forward_controller_if #(.CNT_W(2), .REG_W(5)) ifc ();

  hazard_forward_controller #(.CNT_W(2), .REG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       usesRt;
    logic       regDst;
    logic       regWrite;
    logic       memRead;
    logic       taken;
    logic       expPc;
    logic       expBub;
    logic       expFlush;
    logic       expStall;
    logic [1:0] expFa;
    logic [1:0] expFb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic valid, logic [4:0] rs, logic [4:0] rt,
                             logic [4:0] rd, logic usesRt, logic regDst,
                             logic regWrite, logic memRead, logic taken,
                             int ctl, logic [1:0] fa, logic [1:0] fb);
    vec_t r;
    r.valid    = valid;
    r.rs       = rs;
    r.rt       = rt;
    r.rd       = rd;
    r.usesRt   = usesRt;
    r.regDst   = regDst;
    r.regWrite = regWrite;
    r.memRead  = memRead;
    r.taken    = taken;
    r.expPc    = (ctl != S);
    r.expBub   = (ctl != N);
    r.expFlush = (ctl == F);
    r.expStall = (ctl == S);
    r.expFa    = fa;
    r.expFb    = fb;
    return r;
  endfunction

  function automatic vec_t nop(logic [1:0] fa, logic [1:0] fb);
    return v(0, 0, 0, 0, 0, 0, 0, 0, 0, N, fa, fb);
  endfunction

  task automatic applyStimulus(input vec_t s);
    ifc.id_valid        = s.valid;
    ifc.id_rs           = s.rs;
    ifc.id_rt           = s.rt;
    ifc.id_rd           = s.rd;
    ifc.id_uses_rt      = s.usesRt;
    ifc.id_RegDst       = s.regDst;
    ifc.id_RegWrite     = s.regWrite;
    ifc.id_MemRead      = s.memRead;
    ifc.ex_branch_taken = s.taken;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    applyStimulus(nop(0, 0));
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int expStallCnt;
    int expFlushCnt;
    checks = 0;
    errors = 0;

    // Reset with a load-use hazard and a taken branch on the inputs.
    reset = 1'b1;
    applyStimulus(v(1, 3, 2, 4, 1, 1, 1, 1, 1, N, 0, 0));
    #1;
    checkOutput("rst0_flush", 0, 16'(ifc.flush), 16'd0);
    checkOutput("rst0_pc", 0, 16'(ifc.pc_write), 16'd1);
    checkOutput("rst0_fa", 0, 16'(ifc.forward_a), 16'd0);
    checkOutput("rst0_fb", 0, 16'(ifc.forward_b), 16'd0);
    for (int c = 1; c <= 2; c++) begin
      step();
      checkOutput("rst_flush", c, 16'(ifc.flush), 16'd0);
      checkOutput("rst_pc", c, 16'(ifc.pc_write), 16'd1);
      checkOutput("rst_ifid", c, 16'(ifc.ifid_write), 16'd1);
      checkOutput("rst_bub", c, 16'(ifc.idex_bubble), 16'd0);
      checkOutput("rst_fa", c, 16'(ifc.forward_a), 16'd0);
      checkOutput("rst_fb", c, 16'(ifc.forward_b), 16'd0);
      checkOutput("rst_scnt", c, 16'(ifc.stall_count), 16'd0);
      checkOutput("rst_fcnt", c, 16'(ifc.flush_count), 16'd0);
    end
    reset = 1'b0;
    #1;
    checkOutput("post_rst_flush", 3, 16'(ifc.flush), 16'd0);
    checkOutput("post_rst_bub", 3, 16'(ifc.idex_bubble), 16'd0);
    step();
    idle(3);

    // c0..c3: EX forward; c4..c13: MEM-over-WB, then WB-only
    vecs.push_back(v(1, 1, 2, 3, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(v(1, 3, 5, 4, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(nop(2'b10, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));
    vecs.push_back(v(1, 1, 2, 3, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(v(1, 1, 2, 3, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(v(1, 3, 3, 6, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(nop(2'b10, 2'b10));
    vecs.push_back(nop(2'b00, 2'b00));
    vecs.push_back(v(1, 1, 2, 3, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(nop(2'b00, 2'b00));
    vecs.push_back(v(1, 3, 3, 6, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(nop(2'b01, 2'b01));
    vecs.push_back(nop(2'b00, 2'b00));
    // c14..c21: load-use on rs, then a load in MEM that must not forward
    vecs.push_back(v(1, 1, 3, 0, 0, 0, 1, 1, 0, N, 0, 0));
    vecs.push_back(v(1, 3, 2, 4, 1, 1, 1, 0, 0, S, 0, 0));
    vecs.push_back(v(1, 3, 2, 4, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(nop(2'b01, 2'b00));
    vecs.push_back(v(1, 1, 3, 0, 0, 0, 1, 1, 0, N, 0, 0));
    vecs.push_back(v(1, 1, 3, 0, 0, 0, 1, 0, 0, N, 0, 0));
    vecs.push_back(nop(2'b00, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));
    // c22..c28: register $0 never stalls or forwards
    vecs.push_back(v(1, 1, 0, 0, 0, 0, 1, 1, 0, N, 0, 0));
    vecs.push_back(v(1, 0, 0, 4, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(nop(2'b00, 2'b00));
    vecs.push_back(v(1, 1, 2, 0, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(v(1, 0, 0, 5, 1, 1, 1, 0, 0, N, 0, 0));
    vecs.push_back(nop(2'b00, 2'b00));
    vecs.push_back(nop(2'b00, 2'b00));
    // c29..c32: flush beats load-use; taken with empty EX does nothing
    vecs.push_back(v(1, 1, 3, 0, 0, 0, 1, 1, 0, N, 0, 0));
    vecs.push_back(v(1, 3, 2, 4, 1, 1, 1, 0, 1, F, 0, 0));
    vecs.push_back(v(1, 3, 2, 4, 1, 1, 1, 0, 1, N, 0, 0));
    vecs.push_back(nop(2'b01, 2'b00));
    // c33..c36: load-use through rt
    vecs.push_back(v(1, 1, 5, 0, 0, 0, 1, 1, 0, N, 0, 0));
    vecs.push_back(v(1, 2, 5, 0, 1, 0, 0, 0, 0, S, 0, 0));
    vecs.push_back(v(1, 2, 5, 0, 1, 0, 0, 0, 0, N, 0, 0));
    vecs.push_back(nop(2'b00, 2'b01));

    expStallCnt = 0;
    expFlushCnt = 0;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput("pc_write", i, 16'(ifc.pc_write), 16'(vecs[i].expPc));
      checkOutput("ifid_write", i, 16'(ifc.ifid_write), 16'(vecs[i].expPc));
      checkOutput("idex_bubble", i, 16'(ifc.idex_bubble), 16'(vecs[i].expBub));
      checkOutput("flush", i, 16'(ifc.flush), 16'(vecs[i].expFlush));
      checkOutput("forward_a", i, 16'(ifc.forward_a), 16'(vecs[i].expFa));
      checkOutput("forward_b", i, 16'(ifc.forward_b), 16'(vecs[i].expFb));
      checkOutput("stall_count", i, 16'(ifc.stall_count), 16'(expStallCnt));
      checkOutput("flush_count", i, 16'(ifc.flush_count), 16'(expFlushCnt));
      step();
      if (vecs[i].expStall && expStallCnt < 3) expStallCnt++;
      if (vecs[i].expFlush && expFlushCnt < 3) expFlushCnt++;
    end
    checkOutput("end_stall_count", 99, 16'(ifc.stall_count), 16'd2);
    checkOutput("end_flush_count", 99, 16'(ifc.flush_count), 16'd1);

    // Reset arriving in the middle of a load-use stall
    applyStimulus(v(1, 1, 3, 0, 0, 0, 1, 1, 0, N, 0, 0));
    step();
    applyStimulus(v(1, 3, 2, 4, 1, 1, 1, 0, 0, N, 0, 0));
    #1;
    checkOutput("midstall_pc", 200, 16'(ifc.pc_write), 16'd0);
    reset = 1'b1;
    #1;
    checkOutput("midstall_rst_pc", 201, 16'(ifc.pc_write), 16'd1);
    checkOutput("midstall_rst_bub", 201, 16'(ifc.idex_bubble), 16'd0);
    step();
    reset = 1'b0;
    ifc.ex_branch_taken = 1'b1;
    #1;
    checkOutput("after_rst_pc", 202, 16'(ifc.pc_write), 16'd1);
    checkOutput("after_rst_flush", 202, 16'(ifc.flush), 16'd0);
    checkOutput("after_rst_scnt", 202, 16'(ifc.stall_count), 16'd0);
    checkOutput("after_rst_fcnt", 202, 16'(ifc.flush_count), 16'd0);
    step();
    applyStimulus(nop(0, 0));
    #1;
    checkOutput("after_rst_fa", 203, 16'(ifc.forward_a), 16'd0);
    step();

    // Five load-use pairs with a 2-bit counter: saturates at 3
    for (int k = 0; k < 5; k++) begin
      applyStimulus(v(1, 1, 3, 0, 0, 0, 1, 1, 0, N, 0, 0));
      step();
      applyStimulus(v(1, 3, 2, 4, 1, 1, 1, 0, 0, N, 0, 0));
      #1;
      checkOutput("sat_stall_pc", 300 + k, 16'(ifc.pc_write), 16'd0);
      step();
      checkOutput("sat_resume_pc", 300 + k, 16'(ifc.pc_write), 16'd1);
      step();
      checkOutput("sat_stall_count", 300 + k, 16'(ifc.stall_count),
                  16'((k + 1 < 3) ? k + 1 : 3));
    end
    idle(2);
    checkOutput("sat_final", 399, 16'(ifc.stall_count), 16'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_forward_controller.md
Name: hazard_forward_controller

Overview:
- Pipeline controller sequencing the EX stage of the 5-stage MIPS pipeline.
- Keeps a scoreboard of the instructions in EX, MEM and WB, and drives the operand forwarding selects for the execution module's ALU inputs.
- Detects load-use hazards and stalls PC and IF/ID for one cycle, flushing the younger instructions on a taken branch resolved in EX.
- Keeps saturating stall and flush event counters for debug.

Parameters:
- CNT_W, 16, width of the stall_count and flush_count counters.
- REG_W, 5, register specifier width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  a real instruction is in the ID stage.
- id_rs  in  REG_W  inst[25:21] of the ID instruction.
- id_rt  in  REG_W  inst[20:16] of the ID instruction.
- id_rd  in  REG_W  inst[15:11] of the ID instruction.
- id_uses_rt  in  1  rt is a source operand (R-type, sw, beq).
- id_RegDst  in  1  destination is rd (1) or rt (0).
- id_RegWrite  in  1  the ID instruction writes the register file.
- id_MemRead  in  1  the ID instruction is a load.
- ex_branch_taken  in  1  Branch & zero_out from the EX stage.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID register load enable.
- idex_bubble  out  1  zero the control bits loaded into ID/EX.
- flush  out  1  clear IF/ID; asserts only on a taken branch.
- forward_a  out  2  ALU input A select: 00 = read_data1, 10 = EX/MEM alu_result, 01 = MEM/WB write data.
- forward_b  out  2  ALU input B select, same encoding; applies before the ALUSrc mux.
- stall_count  out  CNT_W  number of load-use stall cycles.
- flush_count  out  CNT_W  number of taken-branch flushes.

Behaviour:
- Scoreboard: three slots, EX, MEM and WB.
  - Each slot holds {valid, regwrite, memread, dest, rs, rt}.
  - dest = id_RegDst ? id_rd : id_rt; the value is captured when the instruction enters EX.
- Every clock edge:
  - WB <= MEM and MEM <= EX.
  - EX <= ID fields if id_valid & !stall & !flush; otherwise EX <= bubble (all fields 0).
- stall (internal) = id_valid & EX.valid & EX.memread & EX.dest != 0 & (EX.dest == id_rs | (id_uses_rt & EX.dest == id_rt)) & !flush.
- flush = EX.valid & ex_branch_taken.
  - flush has priority over stall; the squashed ID instruction causes no stall.
- Output decode (combinational from the slots and the ID inputs), in priority order:
  - flush: pc_write=1, ifid_write=1, idex_bubble=1, flush=1.
  - stall: pc_write=0, ifid_write=0, idex_bubble=1, flush=0.
  - otherwise: pc_write=1, ifid_write=1, idex_bubble=0, flush=0.
- forward_a:
  - 10 if MEM.valid & MEM.regwrite & !MEM.memread & MEM.dest != 0 & MEM.dest == EX.rs.
  - else 01 if WB.valid & WB.regwrite & WB.dest != 0 & WB.dest == EX.rs.
  - else 00.
  - MEM has priority over WB.
  - A load in MEM is never a forwarding source; the load-use stall guarantees the load is in WB by the time the consumer reaches EX.
- forward_b: same rules using EX.rt; forced to 00 when EX.valid = 0.
- Register $0 never forwards and never stalls.
- Counters:
  - stall_count increments in each cycle that stall = 1.
  - flush_count increments in each cycle that flush = 1.
  - Both saturate at all-ones (no wrap).
- Latency:
  - A load-use stall lasts exactly 1 cycle.
  - A taken branch squashes exactly 2 younger instructions (IF/ID via flush, ID/EX via bubble).
  - No back-to-back stall occurs for the same ID instruction.
- Reset (synchronous), while reset is high and in the cycle after:
  - All slots invalid; counters 0.
  - Outputs: pc_write=1, ifid_write=1, idex_bubble=0, flush=0, forward_a=00, forward_b=00.
  - stall and flush are forced 0 while reset is high, regardless of the inputs.
  - Reset in mid-stall cancels the stall; the ID instruction is not captured into EX.

Test Plan:
1. Reset: hold reset 2 cycles with ex_branch_taken=1 and id inputs forming a hazard -> flush=0, pc_write=1, forward_a=forward_b=00, counters 0.
2. EX forward: add $3,$1,$2 followed by sub $4,$3,$5 -> when the sub is in EX, forward_a=10 and forward_b=00; one cycle later there are no matches.
3. WB forward with MEM priority: add $3 / or $3 / and $6,$3,$3 -> with the and in EX, forward_a=forward_b=10 (MEM wins over WB); with the or removed, the result is 01.
4. Load-use: lw $3,0($1) followed by add $4,$3,$2 (id_uses_rt=1) -> 1 cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_count=1; the add then reaches EX with forward_a=01.
5. $0 and branch priority: lw $0 followed by add $4,$0,$0 gives no stall. A taken beq in EX in the same cycle as a load-use in ID gives flush=1, stall=0, flush_count=1, and a bubble in EX on the next cycle.
6. Saturation: with CNT_W=2, run 5 consecutive load-use pairs -> stall_count holds at 3.
